// File: rtl/cache_wt_pkg.sv
// Shared types and helpers for the write-through associative cache.
// - state_t      : controller state (IDLE, RD_MEM, WR_MEM)
// - calc_tag_w   : tag width from address/index/offset widths
// - addr_split_t : {tag, index, offset} view of a word address
// - addr_tag/addr_index/addr_offset : field extraction helpers
package cache_wt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_MEM = 2'd1,
        WR_MEM = 2'd2
    } state_t;

    // Fields are 32 bits wide so one type serves any geometry; callers
    // truncate to their own TAG_W/INDEX_W/OFFSET_W.
    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] index;
        logic [31:0] offset;
    } addr_split_t;

    function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic addr_split_t split_addr(input logic [31:0] addr, input int index_w,
                                               input int offset_w);
        addr_split_t s;
        s.offset = addr & ((32'd1 << offset_w) - 32'd1);
        s.index  = (addr >> offset_w) & ((32'd1 << index_w) - 32'd1);
        s.tag    = addr >> (offset_w + index_w);
        return s;
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w,
                                             input int offset_w);
        addr_split_t s;
        s = split_addr(addr, index_w, offset_w);
        return s.tag;
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w,
                                               input int offset_w);
        addr_split_t s;
        s = split_addr(addr, index_w, offset_w);
        return s.index;
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int index_w,
                                                input int offset_w);
        addr_split_t s;
        s = split_addr(addr, index_w, offset_w);
        return s.offset;
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid bits, tag array and block data.
// Ports:
//   clk, reset            clock, async active-high reset (clears valid bits only)
//   i_index/i_tag/i_offset  split request address
//   i_fill_en, i_fill_block  write a whole block + tag and set valid
//   i_word_we, i_wdata     overwrite one word of a resident block
//   o_valid, o_hit, o_rdata  lookup results for the addressed set/word
module cache_way #(
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [INDEX_W-1:0]         i_index,
    input  logic [TAG_W-1:0]           i_tag,
    input  logic [OFFSET_W-1:0]        i_offset,
    input  logic                       i_fill_en,
    input  logic [(32<<OFFSET_W)-1:0]  i_fill_block,
    input  logic                       i_word_we,
    input  logic [31:0]                i_wdata,
    output logic                       o_valid,
    output logic                       o_hit,
    output logic [31:0]                o_rdata
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag [SETS];
    logic [31:0]      r_data [WORDS][SETS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_index] <= i_tag;
        end
    end

    // One storage bank per word position; a refill writes all banks at once,
    // so a block becomes visible atomically together with its valid bit.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (i_fill_en) begin
                    r_data[gi][i_index] <= i_fill_block[gi*32 +: 32];
                end else if (i_word_we && (i_offset == OFFSET_W'(gi))) begin
                    r_data[gi][i_index] <= i_wdata;
                end
            end
        end
    endgenerate

    assign o_valid = r_valid[i_index];
    assign o_hit   = o_valid && (r_tag[i_index] == i_tag);
    assign o_rdata = r_data[i_offset][i_index];

endmodule

// File: rtl/cache_wt_assoc.sv
// Write-through, no-write-allocate cache with 1 or 2 ways and LRU replacement.
// Ports:
//   clk, reset                     clock, async active-high reset
//   address/write_data/write_en/read_en  core request (held while stall=1)
//   stall, read_data               core response
//   mem_read/mem_write/mem_addr/mem_wdata/mem_ready/mem_rdata_block  memory side
//   hit_count, miss_count          saturating read hit/miss counters
module cache_wt_assoc
    import cache_wt_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 2,
    parameter int WAYS     = 2,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          address,
    input  logic [31:0]                write_data,
    input  logic                       write_en,
    input  logic                       read_en,
    output logic                       stall,
    output logic [31:0]                read_data,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ready,
    input  logic [(32<<OFFSET_W)-1:0]  mem_rdata_block,
    output logic [CNT_W-1:0]           hit_count,
    output logic [CNT_W-1:0]           miss_count
);
    localparam int TAG_W = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
    localparam int SETS  = 1 << INDEX_W;

    state_t                r_state, w_state_next;
    logic [SETS-1:0]       r_lru;          // per set: index of least-recently-used way
    logic [CNT_W-1:0]      r_hit_count, r_miss_count;
    logic [31:0]           r_read_data;

    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_W-1:0]    w_index;
    logic [OFFSET_W-1:0]   w_offset;
    logic [WAYS-1:0]       w_valid, w_hit;
    logic [31:0]           w_rdata [WAYS];
    logic                  w_any_hit, w_hit_way, w_victim;
    logic [31:0]           w_hit_data;
    logic                  w_rd_hit, w_rd_miss, w_wr_done;

    assign w_tag    = TAG_W'(addr_tag(32'(address), INDEX_W, OFFSET_W));
    assign w_index  = INDEX_W'(addr_index(32'(address), INDEX_W, OFFSET_W));
    assign w_offset = OFFSET_W'(addr_offset(32'(address), INDEX_W, OFFSET_W));

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            cache_way #(
                .INDEX_W (INDEX_W),
                .OFFSET_W(OFFSET_W),
                .TAG_W   (TAG_W)
            ) u_way (
                .clk         (clk),
                .reset       (reset),
                .i_index     (w_index),
                .i_tag       (w_tag),
                .i_offset    (w_offset),
                .i_fill_en   ((r_state == RD_MEM) && mem_ready && (w_victim == 1'(gi))),
                .i_fill_block(mem_rdata_block),
                .i_word_we   (w_wr_done && w_hit[gi]),
                .i_wdata     (write_data),
                .o_valid     (w_valid[gi]),
                .o_hit       (w_hit[gi]),
                .o_rdata     (w_rdata[gi])
            );
        end
    endgenerate

    assign w_any_hit = |w_hit;

    always_comb begin
        w_hit_data = '0;
        w_hit_way  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit[w]) begin
                w_hit_data = w_rdata[w];
                w_hit_way  = 1'(w);
            end
        end
    end

    // Fill an empty way first (way 0 preferred), otherwise evict the LRU way.
    always_comb begin
        if (WAYS == 1)               w_victim = 1'b0;
        else if (!w_valid[0])        w_victim = 1'b0;
        else if (!w_valid[WAYS-1])   w_victim = 1'b1;
        else                         w_victim = r_lru[w_index];
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_rd_hit     = 1'b0;
        w_rd_miss    = 1'b0;
        w_wr_done    = 1'b0;
        case (r_state)
            IDLE: begin
                // A store wins over a simultaneous load.
                if (write_en) begin
                    stall        = 1'b1;
                    w_state_next = WR_MEM;
                end else if (read_en) begin
                    if (w_any_hit) begin
                        w_rd_hit = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        w_rd_miss    = 1'b1;
                        w_state_next = RD_MEM;
                    end
                end
            end
            RD_MEM: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                mem_addr = {w_tag, w_index, {OFFSET_W{1'b0}}};
                if (mem_ready) w_state_next = IDLE;
            end
            WR_MEM: begin
                mem_write = 1'b1;
                mem_addr  = address;
                mem_wdata = write_data;
                // Release the core in the completion cycle itself.
                stall     = !mem_ready;
                if (mem_ready) begin
                    w_wr_done    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lru        <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_read_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_rd_hit) begin
                r_read_data <= w_hit_data;
                if (r_hit_count != {CNT_W{1'b1}}) r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_rd_miss && (r_miss_count != {CNT_W{1'b1}})) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
            if (w_rd_hit || (w_wr_done && w_any_hit)) begin
                r_lru[w_index] <= ~w_hit_way;
            end
        end
    end

    // Combinational bypass on a hit; otherwise hold the last returned word.
    assign read_data  = w_rd_hit ? w_hit_data : r_read_data;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
